// File: rtl/islip_pkg.sv
// Shared iSLIP types and helpers: scheduler state encoding, one-hot pointer
// rotation and iteration-counter width derivation.
package islip_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        OFFER,
        DONE
    } islip_state_t;

    // Widest request vector the rotate helper supports.
    localparam int unsigned ISLIP_MAX_N = 256;
    localparam int unsigned ISLIP_IDXW  = 8;

    function automatic int unsigned islip_itw(input int unsigned iter);
        int unsigned w;
        w = $clog2(iter);
        return (w < 1) ? 1 : w;
    endfunction

    // Rotate the low n bits of v left by one; bit n-1 wraps to bit 0.
    function automatic logic [ISLIP_MAX_N-1:0] islip_rotl1(
        input logic [ISLIP_MAX_N-1:0] v,
        input int unsigned            n
    );
        logic [ISLIP_MAX_N-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < ISLIP_MAX_N; i++) begin
            if (i < n) begin
                r[ISLIP_IDXW'((i + 1) % n)] = v[ISLIP_IDXW'(i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/islip_rr_ptr_reg.sv
// One-hot round-robin pointer register: on upd_en the pointer moves to one past
// the supplied one-hot position. Shared by the grant and accept arbiters.
module islip_rr_ptr_reg
    import islip_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         upd_en,
    input  logic [N-1:0] upd_onehot,
    output logic [N-1:0] ptr
);

    logic [N-1:0] ptr_next;

    always_comb begin
        ptr_next = N'(islip_rotl1(ISLIP_MAX_N'(upd_onehot), N));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= N'(1);
        end else if (upd_en) begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/islip_grant_ptr_ctrl.sv
// Per-output iSLIP grant controller: feeds the priority encoder, offers its grant
// and keeps the round-robin pointer. ISLIP_GRANT_STATS_EN adds accept/reject counters.
module islip_grant_ptr_ctrl
    import islip_pkg::*;
#(
    parameter int unsigned N    = 32,
    parameter int unsigned ITER = 4,
    parameter int unsigned ITW  = islip_itw(ITER)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           sched_start,
    input  logic [N-1:0]   req_in,
    input  logic [N-1:0]   in_matched,
    output logic [N-1:0]   enc_req,
    output logic [N-1:0]   enc_ptr,
    input  logic [N-1:0]   enc_grant,
    output logic           grant_valid,
    output logic [N-1:0]   grant_vec,
    input  logic           grant_accept,
    input  logic           grant_reject,
    output logic [ITW-1:0] iter_idx,
    output logic           sched_done,
    output logic           matched
`ifdef ISLIP_GRANT_STATS_EN
    ,
    output logic [15:0]    accept_cnt,
    output logic [15:0]    reject_cnt
`endif
);

    localparam logic [ITW-1:0] LAST_ITER = ITW'(ITER - 1);

    islip_state_t   state_q, state_d;
    logic [ITW-1:0] iter_q, iter_d;
    logic [N-1:0]   gvec_q, gvec_d;
    logic           matched_q, matched_d;
    logic           ptr_upd;

    assign enc_req = req_in & ~in_matched;

    islip_rr_ptr_reg #(
        .N (N)
    ) u_ptr (
        .clk        (clk),
        .rst_n      (rst_n),
        .upd_en     (ptr_upd),
        .upd_onehot (gvec_q),
        .ptr        (enc_ptr)
    );

    always_comb begin
        state_d   = state_q;
        iter_d    = iter_q;
        gvec_d    = gvec_q;
        matched_d = matched_q;
        ptr_upd   = 1'b0;
        case (state_q)
            IDLE: begin
                if (sched_start) begin
                    state_d   = ARB;
                    iter_d    = '0;
                    matched_d = 1'b0;
                    gvec_d    = '0;
                end
            end
            ARB: begin
                if (|enc_grant) begin
                    gvec_d  = enc_grant;
                    state_d = OFFER;
                end else if (iter_q == LAST_ITER) begin
                    state_d = DONE;
                end else begin
                    iter_d = iter_q + 1'b1;
                end
            end
            OFFER: begin
                // Accept has priority; only a first-iteration accept moves the pointer.
                if (grant_accept) begin
                    matched_d = 1'b1;
                    ptr_upd   = (iter_q == '0);
                    state_d   = DONE;
                end else if (grant_reject) begin
                    gvec_d = '0;
                    if (iter_q == LAST_ITER) begin
                        state_d = DONE;
                    end else begin
                        iter_d  = iter_q + 1'b1;
                        state_d = ARB;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            iter_q    <= '0;
            gvec_q    <= '0;
            matched_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            iter_q    <= iter_d;
            gvec_q    <= gvec_d;
            matched_q <= matched_d;
        end
    end

    assign grant_valid = (state_q == OFFER);
    assign sched_done  = (state_q == DONE);
    assign grant_vec   = gvec_q;
    assign iter_idx    = iter_q;
    assign matched     = matched_q;

`ifdef ISLIP_GRANT_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            accept_cnt <= '0;
            reject_cnt <= '0;
        end else if (state_q == OFFER) begin
            if (grant_accept) begin
                if (accept_cnt != '1) accept_cnt <= accept_cnt + 16'd1;
            end else if (grant_reject) begin
                if (reject_cnt != '1) reject_cnt <= reject_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_islip_grant_ptr_ctrl.sv
// Bench for islip_grant_ptr_ctrl (N=8, ITER=4): directed rounds with literal
// expectations, then randomized rounds checked against a round-level model.
module tb_islip_grant_ptr_ctrl;

    localparam int unsigned N    = 8;
    localparam int unsigned ITER = 4;
    localparam int unsigned ITW  = 2;

    localparam int P_IDLE   = 0;
    localparam int P_SEARCH = 1;
    localparam int P_OFFER  = 2;
    localparam int P_FINISH = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           sched_start = 1'b0;
    logic [N-1:0]   req_in = '0;
    logic [N-1:0]   in_matched = '0;
    logic [N-1:0]   enc_req;
    logic [N-1:0]   enc_ptr;
    logic [N-1:0]   enc_grant;
    logic           grant_valid;
    logic [N-1:0]   grant_vec;
    logic           grant_accept = 1'b0;
    logic           grant_reject = 1'b0;
    logic [ITW-1:0] iter_idx;
    logic           sched_done;
    logic           matched;
`ifdef ISLIP_GRANT_STATS_EN
    logic [15:0]    accept_cnt;
    logic [15:0]    reject_cnt;
`endif

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    islip_grant_ptr_ctrl #(
        .N    (N),
        .ITER (ITER),
        .ITW  (ITW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sched_start  (sched_start),
        .req_in       (req_in),
        .in_matched   (in_matched),
        .enc_req      (enc_req),
        .enc_ptr      (enc_ptr),
        .enc_grant    (enc_grant),
        .grant_valid  (grant_valid),
        .grant_vec    (grant_vec),
        .grant_accept (grant_accept),
        .grant_reject (grant_reject),
        .iter_idx     (iter_idx),
        .sched_done   (sched_done),
        .matched      (matched)
`ifdef ISLIP_GRANT_STATS_EN
        ,
        .accept_cnt   (accept_cnt),
        .reject_cnt   (reject_cnt)
`endif
    );

    function automatic bit bit_at(input logic [N-1:0] v, input int i);
        return ((v >> i) & N'(1)) != '0;
    endfunction

    // Index of the first available input at or after start, wrapping; -1 if none.
    function automatic int rr_pick(input logic [N-1:0] avail, input int start);
        int j;
        for (int k = 0; k < N; k++) begin
            j = (start + k) % N;
            if (bit_at(avail, j)) return j;
        end
        return -1;
    endfunction

    // Stand-in for the parent's programmable priority encoder.
    function automatic logic [N-1:0] ppe(input logic [N-1:0] r, input logic [N-1:0] p);
        int s;
        int g;
        s = 0;
        for (int i = 0; i < N; i++) if (bit_at(p, i)) s = i;
        g = rr_pick(r, s);
        return (g < 0) ? '0 : (N'(1) << g);
    endfunction

    always_comb enc_grant = ppe(enc_req, enc_ptr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Round-level model: pointer as an input index, offer as the chosen index.
    int           m_ptr = 0;
    int           m_phase = P_IDLE;
    int           m_iter = 0;
    int           m_off = -1;
    logic [N-1:0] m_gvec = '0;
    bit           m_matched = 1'b0;
    int           m_acc = 0;
    int           m_rej = 0;
    bit           model_live = 1'b0;

    initial begin
        int g;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_ptr = 0; m_phase = P_IDLE; m_iter = 0; m_off = -1;
                m_gvec = '0; m_matched = 1'b0; m_acc = 0; m_rej = 0;
                model_live = 1'b1;
            end else begin
                case (m_phase)
                    P_IDLE: if (sched_start) begin
                        m_phase = P_SEARCH; m_iter = 0; m_matched = 1'b0; m_gvec = '0;
                    end
                    P_SEARCH: begin
                        g = rr_pick(req_in & ~in_matched, m_ptr);
                        if (g >= 0) begin
                            m_off = g; m_gvec = N'(1) << g; m_phase = P_OFFER;
                        end else if (m_iter == ITER - 1) m_phase = P_FINISH;
                        else m_iter++;
                    end
                    P_OFFER: begin
                        if (grant_accept) begin
                            m_matched = 1'b1;
                            if (m_iter == 0) m_ptr = (m_off + 1) % N;
                            if (m_acc < 65535) m_acc++;
                            m_phase = P_FINISH;
                        end else if (grant_reject) begin
                            m_gvec = '0;
                            if (m_rej < 65535) m_rej++;
                            if (m_iter == ITER - 1) m_phase = P_FINISH;
                            else begin m_iter++; m_phase = P_SEARCH; end
                        end
                    end
                    default: m_phase = P_IDLE;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            chk("enc_ptr",     32'(enc_ptr),     32'(1) << m_ptr);
            chk("enc_req",     32'(enc_req),     32'(req_in & ~in_matched));
            chk("grant_valid", 32'(grant_valid), 32'(m_phase == P_OFFER));
            chk("grant_vec",   32'(grant_vec),   32'(m_gvec));
            chk("iter_idx",    32'(iter_idx),    32'(m_iter));
            chk("sched_done",  32'(sched_done),  32'(m_phase == P_FINISH));
            chk("matched",     32'(matched),     32'(m_matched));
`ifdef ISLIP_GRANT_STATS_EN
            chk("accept_cnt",  32'(accept_cnt),  32'(m_acc));
            chk("reject_cnt",  32'(reject_cnt),  32'(m_rej));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_round(input logic [N-1:0] req, input logic [N-1:0] m);
        req_in = req;
        in_matched = m;
        sched_start = 1'b1;
        step();
        sched_start = 1'b0;
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) step();
        chk("rst_ptr",   32'(enc_ptr),     32'h01);
        chk("rst_valid", 32'(grant_valid), 32'h0);
        chk("rst_done",  32'(sched_done),  32'h0);
        rst_n = 1'b1;
        step();

        start_round(8'h24, 8'h00);
        chk("adv_valid", 32'(grant_valid), 32'h1);
        chk("adv_gvec",  32'(grant_vec),   32'h04);
        grant_accept = 1'b1;
        step();
        grant_accept = 1'b0;
        chk("adv_done",    32'(sched_done), 32'h1);
        chk("adv_matched", 32'(matched),    32'h1);
        chk("adv_ptr",     32'(enc_ptr),    32'h08);
        step();
        chk("adv_done_pulse", 32'(sched_done), 32'h0);
        chk("adv_gvec_hold",  32'(grant_vec),  32'h04);

        start_round(8'h40, 8'h00);
        grant_accept = 1'b1;
        step();
        grant_accept = 1'b0;
        chk("pre_wrap_ptr", 32'(enc_ptr), 32'h80);
        step();
        start_round(8'h81, 8'h00);
        chk("wrap_gvec", 32'(grant_vec), 32'h80);
        grant_accept = 1'b1;
        step();
        grant_accept = 1'b0;
        chk("wrap_ptr", 32'(enc_ptr), 32'h01);
        step();

        start_round(8'h24, 8'h00);
        chk("rej_gvec0", 32'(grant_vec), 32'h04);
        grant_reject = 1'b1;
        in_matched = 8'h04;
        step();
        grant_reject = 1'b0;
        chk("rej_iter1",  32'(iter_idx),    32'h1);
        chk("rej_valid0", 32'(grant_valid), 32'h0);
        step();
        chk("rej_gvec1", 32'(grant_vec), 32'h20);
        grant_accept = 1'b1;
        step();
        grant_accept = 1'b0;
        chk("rej_ptr",     32'(enc_ptr), 32'h01);
        chk("rej_iter",    32'(iter_idx), 32'h1);
        chk("rej_matched", 32'(matched), 32'h1);
        in_matched = 8'h00;
        step();

        req_in = 8'h00;
        sched_start = 1'b1;
        step();
        sched_start = 1'b0;
        for (int i = 0; i < ITER; i++) begin
            chk("noreq_iter",  32'(iter_idx),    32'(i));
            chk("noreq_valid", 32'(grant_valid), 32'h0);
            chk("noreq_done",  32'(sched_done),  32'h0);
            step();
        end
        chk("noreq_fin",  32'(sched_done), 32'h1);
        chk("noreq_ptr",  32'(enc_ptr),    32'h01);
        step();

        start_round(8'h02, 8'h00);
        chk("both_gvec", 32'(grant_vec), 32'h02);
        grant_accept = 1'b1;
        grant_reject = 1'b1;
        step();
        grant_accept = 1'b0;
        grant_reject = 1'b0;
        chk("both_ptr",     32'(enc_ptr), 32'h04);
        chk("both_matched", 32'(matched), 32'h1);
        step();

        start_round(8'h10, 8'h00);
        chk("mrst_valid", 32'(grant_valid), 32'h1);
        rst_n = 1'b0;
        grant_accept = 1'b1;
        step();
        grant_accept = 1'b0;
        chk("mrst_ptr",     32'(enc_ptr),     32'h01);
        chk("mrst_valid0",  32'(grant_valid), 32'h0);
        chk("mrst_gvec",    32'(grant_vec),   32'h0);
        chk("mrst_iter",    32'(iter_idx),    32'h0);
        chk("mrst_matched", 32'(matched),     32'h0);
        chk("mrst_done",    32'(sched_done),  32'h0);
        rst_n = 1'b1;
        step();

        for (int c = 0; c < 4000; c++) begin
            rst_n = ($urandom_range(0, 599) != 0);
            sched_start = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) req_in = N'($urandom() & $urandom());
            else if ($urandom_range(0, 7) == 0) req_in = N'($urandom());
            in_matched = ($urandom_range(0, 2) == 0) ? N'($urandom() & $urandom()) : '0;
            grant_accept = 1'b0;
            grant_reject = 1'b0;
            if (grant_valid) begin
                case ($urandom_range(0, 5))
                    2: grant_accept = 1'b1;
                    3, 4: grant_reject = 1'b1;
                    5: begin grant_accept = 1'b1; grant_reject = 1'b1; end
                    default: ;
                endcase
            end
            step();
        end
        rst_n = 1'b1;
        sched_start = 1'b0;
        grant_accept = 1'b0;
        grant_reject = 1'b0;
        step();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/islip_grant_ptr_ctrl.md
Name: islip_grant_ptr_ctrl

Overview:
- Per-output grant controller for the iSLIP scheduler; sits directly upstream of the programmable priority encoder.
- Each scheduling round it does three things:
  - drives the encoder with the masked request vector and a one-hot round-robin pointer;
  - registers the encoder's one-hot grant and offers it to the input-side accept arbiters over a valid/accept/reject handshake;
  - runs up to ITER iterations per round.
- The pointer advances to one past the granted input only when the grant is accepted in the first iteration (iSLIP rule).

Parameters:
- N, 32, number of inputs (request/grant vector width)
- ITER, 4, maximum iSLIP iterations per scheduling round (>=1)
- ITW, 2, width of iteration counter, >= clog2(ITER), min 1

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous reset, active-low
- sched_start  input  1  pulse: begin a scheduling round
- req_in  input  N  input requests to this output (bit i = input i)
- in_matched  input  N  inputs already matched in earlier iterations of this round
- enc_req  output  N  req_in & ~in_matched, combinational, to encoder in_req
- enc_ptr  output  N  one-hot round-robin pointer, to encoder in_p_enc
- enc_grant  input  N  one-hot grant from encoder (all-zero = no grant)
- grant_valid  output  1  grant_vec is being offered
- grant_vec  output  N  registered one-hot grant
- grant_accept  input  1  granted input accepts (valid only with grant_valid)
- grant_reject  input  1  granted input rejects (valid only with grant_valid)
- iter_idx  output  ITW  current iteration number
- sched_done  output  1  one-cycle pulse: round finished
- matched  output  1  this output matched in the current/last round; cleared at sched_start

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low.
- Reset values (rst_n=0 at a clk edge):
  - enc_ptr = 1 (bit 0);
  - grant_valid=0, grant_vec=0, iter_idx=0, sched_done=0, matched=0;
  - state=IDLE.
- Reset mid-round aborts the round. Any handshake in that cycle is ignored; the pointer is not updated.
- FSM states:
  - IDLE:
    - sched_start=1 -> ARB, with iter_idx<=0 and matched<=0.
    - sched_start is ignored in every other state.
  - ARB:
    - Samples enc_grant (encoder is combinational; 1-cycle latency from ARB entry to offer).
    - If enc_grant != 0: grant_vec<=enc_grant, grant_valid<=1 -> OFFER.
    - Else if iter_idx==ITER-1 -> DONE.
    - Else iter_idx++, stay ARB.
  - OFFER:
    - grant_valid and grant_vec are held stable until a response arrives; there is no timeout.
    - grant_accept=1 -> matched<=1, grant_valid<=0 -> DONE.
      - Pointer update on accept, only if iter_idx==0: enc_ptr <= grant_vec rotated left by one (bit N-1 wraps to bit 0).
    - grant_reject=1 (accept=0):
      - grant_valid<=0, grant_vec<=0;
      - if iter_idx==ITER-1 -> DONE, else iter_idx++ -> ARB.
    - Accept and reject both high: accept wins.
  - DONE: sched_done=1 for exactly one cycle -> IDLE. grant_vec keeps its last accepted value until the next sched_start.
- Pointer semantics:
  - Search starts at the pointer bit and wraps upward.
  - The pointer is never modified on iterations >0, on reject, or with no grant.
- enc_req is recomputed combinationally each cycle. Changes to in_matched during OFFER do not alter an offered grant.
- N=1: the pointer stays 1 (rotation of bit 0 wraps to bit 0).

Optional Feature:
- Macro ISLIP_GRANT_STATS_EN.
- When defined:
  - adds output accept_cnt [15:0], which increments on each accepted grant and saturates at 16'hFFFF;
  - adds output reject_cnt [15:0], which increments on each reject and saturates at 16'hFFFF;
  - both reset to 0 on rst_n.
- When undefined, neither port nor its counter exists; all other behaviour is identical.

Decomposition:
- Shared package islip_pkg holds:
  - state enum (IDLE, ARB, OFFER, DONE);
  - the rotate-left-by-one function for one-hot pointers;
  - the ITW derivation helper.
- Natural sub-module: islip_rr_ptr_reg, the one-hot pointer register with the update-enable and rotate logic. It is reused by the input-side accept arbiter.
- The priority encoder is instantiated by the parent, not inside this block.

Test Plan:
- Reset then idle -> enc_ptr=0x1, grant_valid=0, sched_done=0; N=8 assumed below.
- Pointer advance: req_in=0x24, ptr=0x1, enc_grant=0x04, accept in iter0 -> enc_ptr=0x08, matched=1, sched_done one cycle after accept.
- Wrap: ptr=0x80, accept of grant 0x80 -> enc_ptr=0x01.
- Reject path: grant 0x04 rejected in iter0, then in_matched=0x04 and new grant 0x20 accepted in iter1 -> enc_ptr unchanged, iter_idx=1, matched=1.
- No requests, ITER=4 -> ARB for 4 cycles (iter_idx 0..3), then sched_done, grant_valid never asserted, pointer unchanged.
- Accept+reject same cycle in iter0 with grant 0x02 -> treated as accept, enc_ptr=0x04. Separately: rst_n low during OFFER -> all outputs return to reset values next edge.
